imem_line_fill: RTL

Instruction-side line filler between the fetch stage's L1 instruction cache and the word-wide instruction memory bus. It accepts a cache-line read request, reads the 8 words of that 32-byte line in ascending order, and returns the full 256-bit line with a one-cycle done pulse. It keeps a one-entry last-line buffer, so a repeated miss to the same line (e.g. after an L1 conflict eviction) is answered without a bus access.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/imem_line_fill_if.sv | 27 ++
 rtl/imem_line_fill.sv | 114 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-side line geometry and the line filler state encoding.
// Used by the line filler, its bus interface and the L1 icache.
package fetch_pkg;

    localparam int LINE_BYTES       = 32;
    localparam int LINE_OFFSET_BITS = 5;
    localparam int LINE_W           = 256;
    localparam int WORD_W           = 32;
    localparam int LINE_WORDS       = LINE_W / WORD_W;
    localparam int BEAT_W           = 3;
    localparam int TAG_W            = 32 - LINE_OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } fill_state_e;

endpackage

// File: rtl/imem_line_fill_if.sv
// Bundle between the L1 icache, the line filler and the word-wide
// instruction memory bus; slave = filler side, master = icache + memory side.
interface imem_line_fill_if
    import fetch_pkg::*;
    ;

    logic              req_read;
    logic [31:0]       req_addr;
    logic              done;
    logic [LINE_W-1:0] read_data;
    logic              inv;
    logic              mem_rd_en;
    logic [31:0]       mem_rd_addr;
    logic              mem_rd_valid;
    logic [WORD_W-1:0] mem_rd_data;

    modport slave (
        input  req_read, req_addr, inv, mem_rd_valid, mem_rd_data,
        output done, read_data, mem_rd_en, mem_rd_addr
    );

    modport master (
        output req_read, req_addr, inv, mem_rd_valid, mem_rd_data,
        input  done, read_data, mem_rd_en, mem_rd_addr
    );

endinterface

// File: rtl/imem_line_fill.sv
// Instruction line filler: reads a 32-byte line as 8 ascending word beats,
// returns it with a one-cycle done pulse, and keeps a one-entry last-line
// buffer so a repeated miss to the same line needs no bus access.
// Ports: sys_clk, rst_n (async, active low); bus.slave carries the icache
// request (req_read/req_addr/inv -> done/read_data) and the memory side
// (mem_rd_en/mem_rd_addr -> mem_rd_valid/mem_rd_data).
module imem_line_fill
    import fetch_pkg::*;
(
    input  logic            sys_clk,
    input  logic            rst_n,
    imem_line_fill_if.slave bus
);

    fill_state_e       state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [TAG_W-1:0]  line_tag_q, line_tag_d;
    logic [TAG_W-1:0]  buf_tag_q, buf_tag_d;
    logic              line_valid_q, line_valid_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic [31:0]       rd_addr_q, rd_addr_d;
    logic [LINE_W-1:0] data_q, data_d;

    logic [TAG_W-1:0]  req_tag;
    logic [BEAT_W-1:0] beat_inc;
    logic              last_beat;
    logic              unused_offset;

    assign req_tag       = bus.req_addr[31:LINE_OFFSET_BITS];
    assign unused_offset = ^bus.req_addr[LINE_OFFSET_BITS-1:0];
    assign beat_inc      = beat_q + BEAT_W'(1);
    assign last_beat     = beat_q == BEAT_W'(LINE_WORDS - 1);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            line_tag_q   <= '0;
            buf_tag_q    <= '0;
            line_valid_q <= 1'b0;
            done_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            line_tag_q   <= line_tag_d;
            buf_tag_q    <= buf_tag_d;
            line_valid_q <= line_valid_d;
            done_q       <= done_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            data_q       <= data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        line_tag_d   = line_tag_q;
        buf_tag_d    = buf_tag_q;
        line_valid_d = line_valid_q;
        done_d       = 1'b0;
        rd_en_d      = rd_en_q;
        rd_addr_d    = rd_addr_q;
        data_d       = data_q;

        if (bus.inv) line_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req_read) begin
                    line_tag_d = req_tag;
                    if (line_valid_q && buf_tag_q == req_tag && !bus.inv) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = FILL;
                        beat_d    = '0;
                        rd_en_d   = 1'b1;
                        rd_addr_d = {req_tag, BEAT_W'(0), 2'b00};
                    end
                end
            end
            FILL: begin
                if (bus.mem_rd_valid) begin
                    data_d[beat_q*WORD_W +: WORD_W] = bus.mem_rd_data;
                    beat_d = beat_inc;
                    if (last_beat) begin
                        // An inv landing on the final beat still delivers
                        // the line but leaves the buffer invalid.
                        state_d      = DONE;
                        done_d       = 1'b1;
                        rd_en_d      = 1'b0;
                        buf_tag_d    = line_tag_q;
                        line_valid_d = !bus.inv;
                    end else begin
                        rd_addr_d = {line_tag_q, beat_inc, 2'b00};
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.done        = done_q;
    assign bus.read_data   = data_q;
    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_rd_addr = rd_addr_q;

endmodule
